// File: rtl/ex_div_unit_if.sv
// Divider handshake bundle between the EX stage (master) and ex_div_unit (slave).
// Carries the operands and control inputs, plus the stall/result signals coming back.
interface ex_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              stall_req;
  logic              result_ready;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output flush, start, signed_div, dividend, divisor,
    input  stall_req, result_ready, quotient, remainder
  );

  modport slave (
    input  flush, start, signed_div, dividend, divisor,
    output stall_req, result_ready, quotient, remainder
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; stalls the pipeline while busy.
// Optional macro DIV_EARLY_OUT_EN: shortcut to DONE when |dividend| < |divisor|.
module ex_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave div_bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    DIVZERO,
    BUSY,
    DONE,
    SHORTCUT
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] dvd_reg;        // dividend magnitude, consumed MSB first
  logic [DATA_W-1:0] dvs_reg;        // divisor magnitude
  logic [DATA_W-1:0] rem_reg;        // partial remainder
  logic [DATA_W-1:0] q_reg;          // quotient bits collected so far
  logic [DATA_W-1:0] raw_dvd_reg;    // untouched dividend for the zero/shortcut results
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [DATA_W-1:0] quotient_reg;
  logic [DATA_W-1:0] remainder_reg;

  logic              stall_req_c;
  logic              result_ready_c;

  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic              accept;
  logic              early_out;
  logic              last_iter;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              trial_ok;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] q_step;

  assign dvd_neg = div_bus.signed_div & div_bus.dividend[DATA_W-1];
  assign dvs_neg = div_bus.signed_div & div_bus.divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? (~div_bus.dividend + 1'b1) : div_bus.dividend;
  assign dvs_mag = dvs_neg ? (~div_bus.divisor + 1'b1) : div_bus.divisor;

  assign accept    = (state_reg == IDLE) && div_bus.start && !div_bus.flush;
  assign last_iter = (cnt_reg == CNT_W'(DATA_W - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: the extra top bit of the trial tells whether the subtraction went negative.
  assign shifted  = {rem_reg, dvd_reg[DATA_W-1]};
  assign trial    = shifted - {1'b0, dvs_reg};
  assign trial_ok = ~trial[DATA_W];
  assign rem_step = trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign q_step   = {q_reg[DATA_W-2:0], trial_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stall_req_c    = 1'b0;
    result_ready_c = 1'b0;
    case (state_reg)
      IDLE: begin
        if (div_bus.start && !div_bus.flush) begin
          stall_req_c = 1'b1;
          if (div_bus.divisor == '0) begin
            state_next = DIVZERO;
          end else if (early_out) begin
            state_next = SHORTCUT;
          end else begin
            state_next = BUSY;
          end
        end
      end
      DIVZERO, SHORTCUT: begin
        stall_req_c = 1'b1;
        state_next  = DONE;
      end
      BUSY: begin
        stall_req_c = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_ready_c = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // The DONE pulse still goes out on a flush; only the next state is overridden.
    if (div_bus.flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      raw_dvd_reg   <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (accept) begin
      cnt_reg     <= '0;
      dvd_reg     <= dvd_mag;
      dvs_reg     <= dvs_mag;
      rem_reg     <= '0;
      q_reg       <= '0;
      raw_dvd_reg <= div_bus.dividend;
      q_neg_reg   <= dvd_neg ^ dvs_neg;
      r_neg_reg   <= dvd_neg;
    end else if (!div_bus.flush) begin
      case (state_reg)
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          dvd_reg <= {dvd_reg[DATA_W-2:0], 1'b0};
          rem_reg <= rem_step;
          q_reg   <= q_step;
          if (last_iter) begin
            // Sign fix-up wraps modulo 2^DATA_W, so MIN / -1 yields MIN with remainder 0.
            quotient_reg  <= q_neg_reg ? (~q_step + 1'b1) : q_step;
            remainder_reg <= r_neg_reg ? (~rem_step + 1'b1) : rem_step;
          end
        end
        DIVZERO: begin
          quotient_reg  <= '1;
          remainder_reg <= raw_dvd_reg;
        end
        SHORTCUT: begin
          quotient_reg  <= '0;
          remainder_reg <= raw_dvd_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_bus.stall_req    = stall_req_c;
  assign div_bus.result_ready = result_ready_c;
  assign div_bus.quotient     = quotient_reg;
  assign div_bus.remainder    = remainder_reg;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU, instantiated in the EX stage. Produces the HI (remainder) and LO (quotient) values that EX places on the EX-to-MEM bus.
- Raises a stall request to the pipeline controller while a division is in flight. This freezes IF/ID/EX and inserts bubbles into MEM until the result is ready.

Parameters:
- DATA_W, 32, operand/result width; quotient/remainder width; iteration count = DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous cancel of the in-flight division (exception/redirect)
- start  in  1  EX holds a DIV/DIVU; held high with stable operands while stall_req=1
- signed_div  in  1  1=DIV (two's complement), 0=DIVU
- dividend  in  DATA_W  rs value
- divisor  in  DATA_W  rt value
- stall_req  out  1  to controller; 1 = hold EX and upstream
- result_ready  out  1  one-cycle pulse; quotient/remainder valid
- quotient  out  DATA_W  LO value, registered
- remainder  out  DATA_W  HI value, registered

Behaviour:
- States:
  - IDLE, DIVZERO, BUSY, DONE.
  - Reset -> IDLE. On reset, quotient=0, remainder=0, result_ready=0, stall_req=0, iteration counter=0.
- IDLE:
  - Condition for a new division: start=1 and flush=0.
  - On that condition, latch operand magnitudes and sign flags, then go to BUSY (divisor!=0) or DIVZERO (divisor==0).
  - stall_req is combinational: high in IDLE whenever start=1 and flush=0, so the starting cycle is already stalled.
- BUSY:
  - Exactly DATA_W cycles, one quotient bit per cycle, MSB first.
  - Each cycle: shift partial remainder left 1 with next dividend bit; subtract |divisor| (DATA_W+1-bit compare); keep result if non-negative and set quotient bit, else restore.
  - After the last iteration -> DONE. stall_req=1 throughout.
- DIVZERO: one cycle, stall_req=1 -> DONE. Result is quotient=all-ones and remainder=dividend (raw input), regardless of signed_div.
- DONE:
  - result_ready=1 and stall_req=0 for exactly one cycle, so EX advances this cycle. Then -> IDLE unconditionally.
  - start seen in the following IDLE cycle belongs to the next instruction.
- Latency:
  - divisor!=0: start accepted at cycle 0, result_ready at cycle DATA_W+1 (33). stall_req high in cycles 0..32.
  - divisor==0: result_ready at cycle 2.
- Sign fix-up on entering DONE, applied when signed_div=1:
  - quotient negated if dividend sign != divisor sign.
  - remainder negated if dividend is negative; the remainder takes the dividend's sign.
  - All arithmetic is modulo 2^DATA_W, so 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
- quotient/remainder hold their value until the next DONE; they are not cleared at start.
- Priority: rst > flush > start.
  - flush in any state -> IDLE next cycle with stall_req=0 and result_ready=0; outputs keep their previous value.
  - flush in the same cycle as start: start ignored.
  - flush during DONE: the result_ready pulse still occurs in that cycle; the unit is in IDLE the next cycle.
- start in BUSY/DIVZERO/DONE is not re-sampled. Operand changes after acceptance are ignored (operands are latched).
- rst mid-division: abort, and all outputs return to reset values next cycle.

Optional Feature:
- DIV_EARLY_OUT_EN.
- Defined: in IDLE with a start that is accepted (divisor!=0), if |dividend| < |divisor| the unit skips BUSY and goes through a one-cycle shortcut to DONE.
  - Result: quotient=0 and remainder=dividend (raw); result_ready at cycle 2.
  - All other cases are unchanged.
- Undefined: every non-zero divisor takes the full 33-cycle path.

Test Plan:
- DIVU 100/7 -> stall_req=1 cycles 0..32; cycle 33: result_ready=1, quotient=14, remainder=2, stall_req=0; cycle 34: result_ready=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, no hang, 33-cycle latency.
- DIVU 5/0 -> result_ready at cycle 2, quotient=0xFFFFFFFF, remainder=5.
- DIVU 100/7 with flush=1 at cycle 10:
  - cycle 11: state IDLE, stall_req=0, no result_ready pulse, previous outputs unchanged.
  - New start DIVU 9/3 -> quotient=3, remainder=0 at its cycle 33.
- With DIV_EARLY_OUT_EN defined: DIVU 3/10 -> result_ready at cycle 2, quotient=0, remainder=3. Without it, the same result arrives at cycle 33.
